keypad_scanner: RTL and testbench

- Scanning decoder for the alarm clock's 4x3 matrix keypad.
- Drives the three column lines one-hot, reads the four row lines, debounces, and encodes the pressed key to a 4-bit code (0-9, 10=[*] alarm, 11=[#] time).
- Emits a one-cycle key_valid strobe per press to the clock control FSM.
- Sits between the keypad pins and the alarm/time-set logic.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_encoder.sv | 32 +++
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, scanner state encoding and default timing for the keypad scanner.
package keypad_pkg;

    localparam int SETTLE_CYCLES_DEF   = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF           = 8;

    localparam logic [3:0] KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3;
    localparam logic [3:0] KEY_4 = 4'd4, KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7;
    localparam logic [3:0] KEY_8 = 4'd8, KEY_9 = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } scan_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_9;
    endfunction

endpackage

// File: rtl/keypad_encoder.sv
// Maps a one-hot (row, column) pair of the 4x3 keypad to its key code; hit_o is low
// for any input that is not exactly one row and one column.
module keypad_encoder
    import keypad_pkg::*;
(
    input  logic [3:0] row_i,
    input  logic [2:0] col_i,
    output logic [3:0] code_o,
    output logic       hit_o
);

    always_comb begin
        code_o = KEY_0;
        hit_o  = 1'b1;
        case ({row_i, col_i})
            7'b1000_100: code_o = KEY_1;
            7'b1000_010: code_o = KEY_2;
            7'b1000_001: code_o = KEY_3;
            7'b0100_100: code_o = KEY_4;
            7'b0100_010: code_o = KEY_5;
            7'b0100_001: code_o = KEY_6;
            7'b0010_100: code_o = KEY_7;
            7'b0010_010: code_o = KEY_8;
            7'b0010_001: code_o = KEY_9;
            7'b0001_100: code_o = KEY_STAR;
            7'b0001_010: code_o = KEY_0;
            7'b0001_001: code_o = KEY_HASH;
            default:     hit_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: one-hot column drive, row sampling, press/release debounce and
// a one-cycle key_valid strobe. Define KEYPAD_SCANNER_REPEAT_EN for auto-repeat on digits.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [2:0] columns,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_PRE     = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             down_q, down_d;
    logic [3:0]       enc_code;
    logic             enc_hit;

`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int             RPT_W          = $clog2(32 * DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(32 * DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT_LAST  = RPT_W'(8 * DEBOUNCE_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_phase_q, rpt_phase_d;
`endif

    function automatic logic [1:0] next_col(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign columns = 3'b001 << col_idx_q;

    keypad_encoder u_encoder (
        .row_i  (row_q),
        .col_i  (columns),
        .code_o (enc_code),
        .hit_o  (enc_hit)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        down_d    = down_q;

        case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if ($onehot(rows)) begin
                        row_d   = rows;
                        state_d = DEBOUNCE;
                    end else begin
                        col_idx_d = next_col(col_idx_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                // The settle-endpoint sample counts as the first of the stable samples.
                if (rows == row_q && enc_hit) begin
                    if (cnt_q == DEB_PRE) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        code_d  = enc_code;
                        valid_d = 1'b1;
                        down_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (rows == '0) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d   = SCAN;
                        cnt_d     = '0;
                        down_d    = 1'b0;
                        col_idx_d = next_col(col_idx_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase

`ifdef KEYPAD_SCANNER_REPEAT_EN
        rpt_d       = '0;
        rpt_phase_d = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            rpt_d       = rpt_q;
            rpt_phase_d = rpt_phase_q;
            if (rows == row_q && is_digit(code_q)) begin
                if (rpt_q == (rpt_phase_q ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
                    rpt_d       = '0;
                    rpt_phase_d = 1'b1;
                    valid_d     = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            cnt_q     <= '0;
            row_q     <= '0;
            code_q    <= KEY_0;
            valid_q   <= 1'b0;
            down_q    <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            down_q    <= down_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rpt_q       <= rpt_d;
            rpt_phase_q <= rpt_phase_d;
`endif
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: behavioural keypad matrix, table of all twelve
// keys, plus hand-written bounce, multi-key, reset and auto-repeat sequences.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SETTLE = 4;
    localparam int DEB    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rows;
    logic [2:0] columns;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [11:0] pressed = '0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs[12];

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int cyc = 0;
    int strobe_cyc[$];
    logic prev_valid = 1'b0;

    keypad_scanner #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows),
        .columns   (columns),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its column line to its row line.
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && columns[c]) rows[r] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n && key_valid) begin
            strobe_cnt++;
            strobe_cyc.push_back(cyc);
            check("valid_not_back_to_back", int'(prev_valid), 0);
        end
        prev_valid = rst_n && key_valid;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [11:0] kbit(input int row, input int col);
        logic [11:0] one;
        one = 12'd1;
        return one << (row * 3 + col);
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_strobe(input string name, input int base, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (strobe_cnt > base) ok = 1'b1;
        end
        check(name, int'(ok), 1);
    endtask

    task automatic wait_release(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (!key_down) ok = 1'b1;
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        int base;
        int first;
        int first_idx;
        int exp_off[5];

        vecs[0]  = '{0, 2, KEY_STAR};
        vecs[1]  = '{0, 0, KEY_HASH};
        vecs[2]  = '{0, 1, 4'd0};
        vecs[3]  = '{3, 2, 4'd1};
        vecs[4]  = '{3, 1, 4'd2};
        vecs[5]  = '{3, 0, 4'd3};
        vecs[6]  = '{2, 2, 4'd4};
        vecs[7]  = '{2, 1, 4'd5};
        vecs[8]  = '{2, 0, 4'd6};
        vecs[9]  = '{1, 2, 4'd7};
        vecs[10] = '{1, 1, 4'd8};
        vecs[11] = '{1, 0, 4'd9};
        exp_off  = '{0, 512, 640, 768, 896};

        // Reset state and idle scanning.
        tick(2);
        check("rst_columns", int'(columns), 1);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_down", int'(key_down), 0);
        rst_n = 1'b1;
        for (int k = 0; k <= 3 * SETTLE; k++) begin
            check("idle_columns", int'(columns), 1 << ((k / SETTLE) % 3));
            check("idle_no_valid", int'(key_valid), 0);
            tick();
        end

        // Key 5 pressed from reset: settled sample in cycle 7, strobe in cycle 23.
        pressed = kbit(2, 1);
        reset_dut();
        base  = strobe_cnt;
        first = -1;
        for (int k = 0; k <= 40; k++) begin
            if (key_valid && first < 0) first = k;
            if (k < 40) tick();
        end
        check("k5_strobe_cycle", first, 23);
        check("k5_columns_frozen", int'(columns), 3'b010);
        check("k5_key_code", int'(key_code), 5);
        check("k5_key_down", int'(key_down), 1);
        tick(60);
        check("k5_one_strobe", strobe_cnt - base, 1);
        pressed = '0;
        tick(DEB - 1);
        check("k5_down_before_release_done", int'(key_down), 1);
        tick();
        check("k5_down_cleared", int'(key_down), 0);
        check("k5_resume_next_column", int'(columns), 3'b100);
        tick(20);

        // Every key through the table.
        for (int v = 0; v < 12; v++) begin
            base    = strobe_cnt;
            pressed = kbit(vecs[v].row, vecs[v].col);
            wait_strobe("tbl_strobe_seen", base, 100);
            check("tbl_key_code", int'(key_code), int'(vecs[v].exp_code));
            check("tbl_columns_held", int'(columns), 1 << vecs[v].col);
            check("tbl_key_down", int'(key_down), 1);
            tick(40);
            pressed = '0;
            wait_release("tbl_release_seen", 60);
            check("tbl_one_strobe", strobe_cnt - base, 1);
            tick(20);
        end

        // Key 7 bouncing every 3 cycles, then held steady.
        base = strobe_cnt;
        for (int i = 0; i < 40; i++) begin
            pressed = (((i / 3) % 2) == 0) ? kbit(1, 2) : '0;
            tick();
        end
        check("bounce_no_strobe", strobe_cnt - base, 0);
        pressed = kbit(1, 2);
        tick(40);
        check("bounce_one_strobe", strobe_cnt - base, 1);
        check("bounce_key_code", int'(key_code), 7);
        pressed = '0;
        wait_release("bounce_release_seen", 60);
        tick(20);

        // Keys 6 and 9 share column 0: multi-hot rows are rejected until one lets go.
        base    = strobe_cnt;
        pressed = kbit(2, 0) | kbit(1, 0);
        tick(60);
        check("multi_no_strobe", strobe_cnt - base, 0);
        pressed = kbit(2, 0);
        wait_strobe("multi_strobe_seen", base, 60);
        check("multi_key_code", int'(key_code), 6);
        tick(20);
        check("multi_one_strobe", strobe_cnt - base, 1);
        pressed = '0;
        wait_release("multi_release_seen", 60);
        tick(20);

        // Reset pulsed while key 3 is in debounce.
        pressed = kbit(3, 0);
        reset_dut();
        base = strobe_cnt;
        tick(10);
        rst_n = 1'b0;
        #1;
        check("midrst_columns", int'(columns), 1);
        check("midrst_key_code", int'(key_code), 0);
        check("midrst_key_valid", int'(key_valid), 0);
        check("midrst_key_down", int'(key_down), 0);
        pressed = '0;
        tick();
        rst_n = 1'b1;
        tick(40);
        check("midrst_no_strobe", strobe_cnt - base, 0);

        // Long hold on a digit: auto-repeat only when the repeat feature is built in.
        base    = strobe_cnt;
        pressed = kbit(3, 0);
        wait_strobe("hold3_strobe_seen", base, 100);
        first_idx = strobe_cyc.size() - 1;
        tick(1000);
        pressed = '0;
        wait_release("hold3_release_seen", 60);
`ifdef KEYPAD_SCANNER_REPEAT_EN
        check("hold3_strobe_count", strobe_cnt - base, 5);
        if (strobe_cyc.size() >= first_idx + 5)
            for (int i = 1; i < 5; i++)
                check("hold3_repeat_offset", strobe_cyc[first_idx+i] - strobe_cyc[first_idx], exp_off[i]);
`else
        check("hold3_strobe_count", strobe_cnt - base, 1);
        check("hold3_code", int'(key_code), 3);
`endif
        tick(20);

        // Long hold on [*]: never repeats.
        base    = strobe_cnt;
        pressed = kbit(0, 2);
        wait_strobe("star_strobe_seen", base, 100);
        tick(600);
        check("star_no_repeat", strobe_cnt - base, 1);
        check("star_code", int'(key_code), 10);
        pressed = '0;
        wait_release("star_release_seen", 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
